// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
//   rpt_state_e : per-channel auto-repeat FSM encoding
//   clog2/max2  : elaboration-time helpers for sizing the repeat counter
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle.
//   btn_in, repeat_en          : raw buttons and per-channel repeat enable (into the block)
//   tick                       : shared sample strobe
//   level, press, rel, rpt, act: debounced level and one-clk event pulses per channel
//   press_cnt                  : per-channel wrapping press counters, channel i at [i*CNT_W +: CNT_W]
// master = board/consumer side, slave = the conditioner.
interface btn_conditioner_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       btn_in;
    logic [N_CH-1:0]       repeat_en;
    logic                  tick;
    logic [N_CH-1:0]       level;
    logic [N_CH-1:0]       press;
    logic [N_CH-1:0]       rel;
    logic [N_CH-1:0]       rpt;
    logic [N_CH-1:0]       act;
    logic [N_CH*CNT_W-1:0] press_cnt;

    modport master (
        output btn_in, repeat_en,
        input  tick, level, press, rel, rpt, act, press_cnt
    );

    modport slave (
        input  btn_in, repeat_en,
        output tick, level, press, rel, rpt, act, press_cnt
    );
endinterface

// File: rtl/btn_conditioner_channel.sv
// One button channel: 2-FF synchroniser, tick-sampled debounce, press/release
// one-shots, hold-to-auto-repeat FSM and wrapping press counter.
//   clk, rst   : clock, async active-high reset
//   tick       : shared sample strobe from the prescaler
//   btn_in     : raw asynchronous button
//   repeat_en  : auto-repeat enable (clk domain)
//   level      : debounced level
//   press/rel  : one-clk pulses on debounced rise/fall
//   rpt, act   : auto-repeat pulse, press|rpt
//   press_cnt  : count of presses, wraps
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int STABLE_N    = 2,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_in,
    input  logic             repeat_en,
    output logic             level,
    output logic             press,
    output logic             rel,
    output logic             rpt,
    output logic             act,
    output logic [CNT_W-1:0] press_cnt
);
    // Only the newest STABLE_N-1 past samples take part in the stability test,
    // so that is all the history kept.
    localparam int HW = STABLE_N - 1;
    localparam int RW = clog2(max2(REPEAT_DLY, REPEAT_RATE)) + 1;

    logic          sync1, btn_s;
    logic [HW-1:0] hist;
    logic          stable, rise, fall, rpt_d;
    rpt_state_e    state;
    logic [RW-1:0] rcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
        end
    end

    assign stable = (hist == {HW{btn_s}});
    assign rise   = tick & stable &  btn_s & ~level;
    assign fall   = tick & stable & ~btn_s &  level;
    // A release on the same tick wins over a due repeat.
    assign rpt_d  = (state != IDLE) & ~fall & repeat_en & tick & (rcnt == RW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            press_cnt <= '0;
        end else begin
            press <= rise;
            rel   <= fall;
            if (tick)        hist      <= HW'({hist, btn_s});
            if (rise | fall) level     <= btn_s;
            if (rise)        press_cnt <= press_cnt + 1'b1;
        end
    end

    // Entered on the press tick itself, so that tick is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            rpt   <= 1'b0;
            act   <= 1'b0;
        end else begin
            rpt <= rpt_d;
            act <= rise | rpt_d;
            case (state)
                IDLE: begin
                    if (rise && repeat_en) begin
                        state <= HOLD;
                        rcnt  <= RW'(REPEAT_DLY);
                    end
                end
                HOLD, RPT: begin
                    if (fall || !repeat_en) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (rcnt == RW'(1)) begin
                            rcnt  <= RW'(REPEAT_RATE);
                            state <= RPT;
                        end else begin
                            rcnt <= rcnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner. One prescaler produces the sample
// tick shared by all channels; each channel is an independent btn_channel.
//   clk, rst : clock, async active-high reset
//   bus      : btn_conditioner_if slave (buttons in, levels/pulses/counters out)
module btn_conditioner #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 17,
    parameter int STABLE_N    = 2,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 2,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    btn_conditioner_if.slave bus
);
    logic [DIV_W-1:0]            div_cnt;
    logic                        tick;
    logic [N_CH-1:0]             level, press, rel, rpt, act;
    logic [N_CH-1:0][CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= div_cnt + 1'b1;
    end

    assign tick = &div_cnt;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        btn_channel #(
            .STABLE_N    (STABLE_N),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .btn_in    (bus.btn_in[gi]),
            .repeat_en (bus.repeat_en[gi]),
            .level     (level[gi]),
            .press     (press[gi]),
            .rel       (rel[gi]),
            .rpt       (rpt[gi]),
            .act       (act[gi]),
            .press_cnt (cnt[gi])
        );
    end

    assign bus.tick      = tick;
    assign bus.level     = level;
    assign bus.press     = press;
    assign bus.rel       = rel;
    assign bus.rpt       = rpt;
    assign bus.act       = act;
    assign bus.press_cnt = cnt;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table of press/hold cases plus hand
// sequences; expected pulses are queued with their cycle when stimulus is
// driven and checked off as the DUT emits them.
module tb_btn_conditioner;
    localparam int N_CH = 4, DIV_W = 3, STABLE_N = 2, REPEAT_DLY = 3, REPEAT_RATE = 2, CNT_W = 4;
    localparam int TP = 1 << DIV_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_conditioner_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    btn_conditioner #(
        .N_CH(N_CH), .DIV_W(DIV_W), .STABLE_N(STABLE_N),
        .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int cyc; int ch; int kind; } ev_t;   // kind: 0 press, 1 release, 2 rpt
    typedef struct { int ch; int hold; bit ren; int n_rpt; } vec_t;

    ev_t q[$];
    int  checks = 0, failures = 0;
    int  cyc;
    int  obs_press[N_CH], obs_rel[N_CH], obs_rpt[N_CH], exp_cnt[N_CH];

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit pulse(input int i, input int k);
        case (k)
            0:       return bus.press[i];
            1:       return bus.rel[i];
            default: return bus.rpt[i];
        endcase
    endfunction

    function automatic int cnt_of(input int ch);
        return int'(bus.press_cnt[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic observe(input int ch, input int k);
        ev_t e;
        if (k == 0) obs_press[ch]++;
        else if (k == 1) obs_rel[ch]++;
        else obs_rpt[ch]++;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: ch=%0d kind=%0d at cycle %0d, expected no pulse", ch, k, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_ch", ch, e.ch);
            chk("ev_kind", k, e.kind);
            chk("ev_cyc", cyc, e.cyc);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.press[i] | bus.rpt[i] | bus.act[i])
                    chk("act", int'(bus.act[i]), int'(bus.press[i] | bus.rpt[i]));
                for (int k = 0; k < 3; k++)
                    if (pulse(i, k)) observe(i, k);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic align();
        step();
        while (cyc % TP != 0) step();
    endtask

    function automatic int next_tick(input int x);
        int t;
        t = x;
        while (t % TP != TP - 1) t++;
        return t;
    endfunction

    // Cycle in which a level change shows, for btn_in driven just after edge c.
    function automatic int edge_at(input int c);
        return next_tick(c + 2) + TP * (STABLE_N - 1) + 1;
    endfunction

    task automatic push(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc = c; e.ch = ch; e.kind = kind;
        q.push_back(e);
    endtask

    task automatic note_press(input int c, input int ch);
        push(c, ch, 0);
        exp_cnt[ch] = (exp_cnt[ch] + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        for (int i = 0; i < N_CH; i++) exp_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_vec(input int ch, input int hold, input bit ren, input int n_rpt);
        int c, pc, rc, base;
        align();
        bus.repeat_en[ch] = ren;
        bus.btn_in[ch]    = 1'b1;
        c  = cyc;
        pc = edge_at(c);
        rc = edge_at(c + hold);
        note_press(pc, ch);
        if (ren)
            for (int t = pc + TP * REPEAT_DLY; t < rc; t += TP * REPEAT_RATE) push(t, ch, 2);
        push(rc, ch, 1);
        base = obs_rpt[ch];
        wait_until(pc);
        chk("level_up", int'(bus.level[ch]), 1);
        chk("press_cnt", cnt_of(ch), exp_cnt[ch]);
        wait_until(c + hold);
        bus.btn_in[ch] = 1'b0;
        wait_until(rc + 4);
        chk("level_down", int'(bus.level[ch]), 0);
        chk("rpt_count", obs_rpt[ch] - base, n_rpt);
        chk("queue_drained", q.size(), 0);
        bus.repeat_en[ch] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   c, pc, rc, base;

        vecs[0] = '{0,  40, 1'b0, 0};
        vecs[1] = '{1,  20, 1'b1, 0};
        vecs[2] = '{2, 100, 1'b1, 5};
        vecs[3] = '{2, 105, 1'b1, 5};   // repeat due on the release tick is dropped
        vecs[4] = '{3,  48, 1'b1, 2};

        bus.btn_in    = '0;
        bus.repeat_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            obs_press[i] = 0; obs_rel[i] = 0; obs_rpt[i] = 0; exp_cnt[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: tick cadence, everything else quiet.
        for (int k = 0; k < 24; k++) begin
            chk("tick", int'(bus.tick), (cyc % TP == TP - 1) ? 1 : 0);
            chk("idle_level", int'(bus.level), 0);
            if (k == 0) chk("reset_cnt", int'(bus.press_cnt), 0);
            step();
        end

        foreach (vecs[i]) run_vec(vecs[i].ch, vecs[i].hold, vecs[i].ren, vecs[i].n_rpt);

        // Glitches on channel 1: one clk between ticks, then 5 clk across a tick.
        align();
        c    = cyc;
        base = obs_press[1] + obs_rel[1];
        wait_until(c + 1);  bus.btn_in[1] = 1'b1;
        wait_until(c + 2);  bus.btn_in[1] = 1'b0;
        wait_until(c + 12); bus.btn_in[1] = 1'b1;
        wait_until(c + 17); bus.btn_in[1] = 1'b0;
        wait_until(c + 40);
        chk("glitch_level", int'(bus.level[1]), 0);
        chk("glitch_pulses", obs_press[1] + obs_rel[1] - base, 0);

        // Dropping repeat_en while held cancels repeat; raising it again does not restart.
        align();
        c = cyc;
        bus.repeat_en[3] = 1'b1;
        bus.btn_in[3]    = 1'b1;
        pc = edge_at(c);
        rc = edge_at(c + 70);
        note_press(pc, 3);
        push(rc, 3, 1);
        base = obs_rpt[3];
        wait_until(c + 30); bus.repeat_en[3] = 1'b0;
        wait_until(c + 35); bus.repeat_en[3] = 1'b1;
        wait_until(c + 70); bus.btn_in[3] = 1'b0;
        wait_until(rc + 4);
        chk("ren_drop_rpt", obs_rpt[3] - base, 0);
        chk("ren_drop_queue", q.size(), 0);
        bus.repeat_en[3] = 1'b0;

        // Channels 0 and 3 together, then 16 more presses on channel 0 to wrap.
        do_reset();
        align();
        c = cyc;
        bus.btn_in[0] = 1'b1;
        bus.btn_in[3] = 1'b1;
        pc = edge_at(c);
        rc = edge_at(c + 30);
        note_press(pc, 0);
        note_press(pc, 3);
        push(rc, 0, 1);
        push(rc, 3, 1);
        wait_until(c + 30);
        bus.btn_in[0] = 1'b0;
        bus.btn_in[3] = 1'b0;
        wait_until(rc + 4);
        chk("simul_queue", q.size(), 0);
        chk("simul_cnt3", cnt_of(3), 1);
        for (int n = 0; n < 16; n++) run_vec(0, 24, 1'b0, 0);
        chk("cnt_wrap", cnt_of(0), 1);

        // Reset while channel 2 is repeating, button kept held through reset.
        align();
        c = cyc;
        bus.repeat_en[2] = 1'b1;
        bus.btn_in[2]    = 1'b1;
        pc = edge_at(c);
        note_press(pc, 2);
        push(pc + TP * REPEAT_DLY, 2, 2);
        wait_until(pc + TP * REPEAT_DLY + 4);
        chk("pre_reset_queue", q.size(), 0);
        rst = 1'b1;
        #1;
        chk("rst_level", int'(bus.level), 0);
        chk("rst_pulses", int'({bus.press, bus.rel, bus.rpt, bus.act}), 0);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_cnt", int'(bus.press_cnt), 0);
        q.delete();
        for (int i = 0; i < N_CH; i++) exp_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pc = edge_at(0);
        note_press(pc, 2);
        rc = edge_at(20);
        push(rc, 2, 1);
        wait_until(pc);
        chk("rerise_level", int'(bus.level[2]), 1);
        chk("rerise_cnt", cnt_of(2), 1);
        wait_until(20);
        bus.btn_in[2] = 1'b0;
        wait_until(60);
        chk("post_reset_queue", q.size(), 0);
        chk("post_reset_level", int'(bus.level[2]), 0);
        bus.repeat_en[2] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised multi-channel push-button conditioner. It replaces the single-button, fixed-divider debounce and edge-detect logic in the board top level.
- Per channel: 2-FF synchroniser, tick-sampled N-sample debounce, press/release one-shots, optional hold-to-auto-repeat FSM, and a wrapping press counter.
- Sits between the raw board buttons and the counter/pause logic; all channels share one prescaler tick.

Parameters:
N_CH, 4, number of button channels
DIV_W, 17, prescaler width; one sample tick every 2^DIV_W clk cycles
STABLE_N, 2, consecutive equal tick samples needed to change the debounced level (>=2)
REPEAT_DLY, 8, ticks after press before the first repeat pulse (>=1)
REPEAT_RATE, 2, ticks between subsequent repeat pulses (>=1)
CNT_W, 8, width of each per-channel press counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_in  in  N_CH  raw asynchronous button inputs
repeat_en  in  N_CH  per-channel auto-repeat enable (synchronous to clk)
tick  out  1  prescaler sample strobe, one clk wide
level  out  N_CH  debounced button level
press  out  N_CH  one-clk pulse on debounced 0->1
release  out  N_CH  one-clk pulse on debounced 1->0
rpt  out  N_CH  one-clk auto-repeat pulse
act  out  N_CH  press | rpt
press_cnt  out  N_CH*CNT_W  per-channel press count; channel i in bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset: all registers async-cleared to 0. This covers the synchronisers, the prescaler, the sample shift registers and rcnt. level, press, release, rpt, act, tick and press_cnt all read 0. FSMs go to IDLE. Reset asserted mid-hold drops any pending repeat with no pulse emitted.
- Synchroniser: btn_in passes through 2 flops per channel; the value reaching the debouncer is btn_s.
- Prescaler: div_cnt (DIV_W bits) increments every clk and wraps. tick = (div_cnt == all ones), decoded from the register. First tick occurs 2^DIV_W-1 cycles after reset release.
- Debounce (per channel), on tick only:
  - smp <= {smp[STABLE_N-2:0], btn_s}.
  - If btn_s and smp[STABLE_N-2:0] are all equal to v, and v != level, then level <= v.
  - level therefore changes only in the cycle after a tick.
  - Glitches shorter than STABLE_N-1 tick periods are rejected.
- Edges: press and release are registered. Each is high for exactly the one cycle in which level first shows its new value.
- Latency, btn_in change to level: 2 clk plus between STABLE_N-1 and STABLE_N tick periods, plus 1 clk.
- press_cnt: +1 on each press (rpt does not count). Wraps modulo 2^CNT_W with no saturation.
- Repeat FSM (per channel), states IDLE, HOLD, RPT; rcnt is a counter of width clog2(max(REPEAT_DLY, REPEAT_RATE))+1.
  - IDLE: on press with repeat_en=1, go to HOLD with rcnt <= REPEAT_DLY.
  - HOLD/RPT: on each tick, if rcnt==1 then rpt <= 1, rcnt <= REPEAT_RATE, state RPT; otherwise rcnt-1.
  - The tick that produced press is not counted. First rpt comes REPEAT_DLY ticks after the press tick; later ones every REPEAT_RATE ticks.
  - Release (level falls) in HOLD or RPT: go to IDLE in the same cycle release pulses. No rpt in that cycle.
  - repeat_en falls in HOLD or RPT: go to IDLE on the next clk. Raising repeat_en while held does not start repeating; a new press is required.
- act = press | rpt, registered in the same cycle as its sources.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.

Decomposition:
- Shared package: repeat-FSM state encoding (IDLE=2'd0, HOLD=2'd1, RPT=2'd2) and a clog2 helper function.
- Top module holds the prescaler and a generate loop of N_CH instances.
- Sub-module btn_channel contains the synchroniser, debounce shift register, edge pulses, repeat FSM and press counter for one channel. It takes tick as an input.

Test Plan:
(Parameters for all scenarios: DIV_W=3, STABLE_N=2, REPEAT_DLY=3, REPEAT_RATE=2, N_CH=4, CNT_W=4.)
1. Reset release, btn_in=0 -> tick first high at cycle 7 and then every 8 cycles; all outputs stay 0.
2. btn_in[0]=1 held 40 cycles, repeat_en=0 -> level[0] rises one cycle after the 2nd tick sampling 1; press[0] and act[0] pulse once; press_cnt[0]=1; no rpt. After release, release[0] pulses once.
3. 1-cycle glitch on btn_in[1] between ticks, then 5-cycle glitch spanning one tick -> level[1] never changes; no pulses.
4. repeat_en[2]=1, btn_in[2] held 100 cycles -> rpt[2] on the 3rd tick after the press tick, then every 2nd tick; act[2] mirrors press|rpt; releasing stops rpt, with no rpt in the release cycle.
5. Channels 0 and 3 pressed in the same cycle -> both press in the same cycle. Press channel 0 17 times -> press_cnt[0] wraps to 1.
6. Assert rst while channel 2 is in RPT -> all outputs 0 immediately. After release of rst with the button still held, level re-rises after 2 ticks, giving a new press and press_cnt=1.
